// File: rtl/head_prune_pkg.sv
// Shared definitions for the attention-head pruning controller.
package head_prune_pkg;

  localparam int unsigned NUM_HEADS_DEF  = 8;
  localparam int unsigned ACC_CYCLES_DEF = 2;
  // Data width of the systolic array feeding the mean unit.
  localparam int unsigned WIDTH          = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StWait,
    StAccum,
    StCompare,
    StSample,
    StFin
  } state_e;

endpackage

// File: rtl/head_prune_ctrl.sv
// Sequences the mean unit over each attention head of a pass and collects
// per-head prune decisions into prune_mask / keep_count.
module head_prune_ctrl
  import head_prune_pkg::*;
#(
  parameter int unsigned NUM_HEADS  = NUM_HEADS_DEF,
  parameter int unsigned ACC_CYCLES = ACC_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           num_heads,
  input  logic                 mat_valid,
  output logic                 mat_ready,
  output logic                 mean_enable,
  output logic                 mean_compare,
  output logic                 mean_reset_n,
  input  logic                 mean_prune,
  output logic [2:0]           head_idx,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_HEADS-1:0] prune_mask,
  output logic [3:0]           keep_count
);

  localparam int unsigned AccW      = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [AccW-1:0] AccLast = AccW'(ACC_CYCLES - 1);
  localparam logic [3:0]   NumHeadsW = 4'(NUM_HEADS);

  state_e                state_q, state_d;
  logic [2:0]            head_idx_q, head_idx_d;
  logic [3:0]            heads_q, heads_d;
  logic [AccW-1:0]       acc_cnt_q, acc_cnt_d;
  logic [NUM_HEADS-1:0]  prune_mask_q, prune_mask_d;
  logic [3:0]            keep_count_q, keep_count_d;
  logic                  mean_enable_q, mean_enable_d;
  logic                  mean_compare_q, mean_compare_d;
  logic                  mean_reset_n_q, mean_reset_n_d;
  logic                  done_q, done_d;
  logic                  abort_hit;

  always_comb begin
    state_d        = state_q;
    head_idx_d     = head_idx_q;
    heads_d        = heads_q;
    acc_cnt_d      = acc_cnt_q;
    prune_mask_d   = prune_mask_q;
    keep_count_d   = keep_count_q;
    abort_hit      = 1'b0;

    if (state_q != StIdle && abort) begin
      state_d   = StIdle;
      abort_hit = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_d      = StClear;
            head_idx_d   = '0;
            prune_mask_d = '0;
            keep_count_d = '0;
            heads_d      = (num_heads == 4'd0 || num_heads > NumHeadsW) ? NumHeadsW : num_heads;
          end
        end
        StClear: state_d = StWait;
        StWait: begin
          if (mat_valid) begin
            state_d   = StAccum;
            acc_cnt_d = '0;
          end
        end
        StAccum: begin
          if (acc_cnt_q == AccLast) state_d = StCompare;
          else acc_cnt_d = acc_cnt_q + 1'b1;
        end
        StCompare: state_d = StSample;
        StSample: begin
          prune_mask_d[head_idx_q] = mean_prune;
          if (!mean_prune) keep_count_d = keep_count_q + 4'd1;
          if ({1'b0, head_idx_q} == heads_q - 4'd1) begin
            state_d = StFin;
          end else begin
            head_idx_d = head_idx_q + 3'd1;
            state_d    = StClear;
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // Mean-unit controls are registered from the next state so they align with it.
    mean_enable_d  = (state_d == StAccum) || (state_d == StCompare);
    mean_compare_d = (state_d == StCompare);
    mean_reset_n_d = !((state_d == StClear) || abort_hit);
    done_d         = (state_q == StFin) && !abort_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      head_idx_q     <= '0;
      heads_q        <= NumHeadsW;
      acc_cnt_q      <= '0;
      prune_mask_q   <= '0;
      keep_count_q   <= '0;
      mean_enable_q  <= 1'b0;
      mean_compare_q <= 1'b0;
      mean_reset_n_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      head_idx_q     <= head_idx_d;
      heads_q        <= heads_d;
      acc_cnt_q      <= acc_cnt_d;
      prune_mask_q   <= prune_mask_d;
      keep_count_q   <= keep_count_d;
      mean_enable_q  <= mean_enable_d;
      mean_compare_q <= mean_compare_d;
      mean_reset_n_q <= mean_reset_n_d;
      done_q         <= done_d;
    end
  end

  assign mat_ready    = (state_q == StSample);
  assign busy         = (state_q != StIdle);
  assign mean_enable  = mean_enable_q;
  assign mean_compare = mean_compare_q;
  assign mean_reset_n = mean_reset_n_q;
  assign done         = done_q;
  assign head_idx     = head_idx_q;
  assign prune_mask   = prune_mask_q;
  assign keep_count   = keep_count_q;

endmodule

// File: tb/tb_head_prune_ctrl.sv
// Directed bench for head_prune_ctrl with default parameters (8 heads, 2 acc cycles).
module tb_head_prune_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, mat_valid;
  logic [3:0] num_heads;
  logic       mat_ready, mean_enable, mean_compare, mean_reset_n, mean_prune;
  logic [2:0] head_idx;
  logic       busy, done;
  logic [7:0] prune_mask;
  logic [3:0] keep_count;
  logic [7:0] pat;

  int tests = 0;
  int fails = 0;
  int en_cnt, cmp_cnt, rdy_cnt, clr_cnt;
  logic [2:0] max_idx;

  head_prune_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .num_heads    (num_heads),
    .mat_valid    (mat_valid),
    .mat_ready    (mat_ready),
    .mean_enable  (mean_enable),
    .mean_compare (mean_compare),
    .mean_reset_n (mean_reset_n),
    .mean_prune   (mean_prune),
    .head_idx     (head_idx),
    .busy         (busy),
    .done         (done),
    .prune_mask   (prune_mask),
    .keep_count   (keep_count)
  );

  // Mean unit stand-in: prune decision per head comes from a pattern.
  assign mean_prune = pat[head_idx];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [3:0] n, input logic [7:0] p);
    num_heads = n;
    pat       = p;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Runs until done; cyc = edges since the current sample, -1 on timeout.
  task automatic wait_done(input int budget, output int cyc);
    cyc     = -1;
    en_cnt  = int'(mean_enable);
    cmp_cnt = int'(mean_compare);
    rdy_cnt = int'(mat_ready);
    clr_cnt = int'(!mean_reset_n);
    max_idx = head_idx;
    for (int i = 1; i <= budget; i++) begin
      step();
      en_cnt  += int'(mean_enable);
      cmp_cnt += int'(mean_compare);
      rdy_cnt += int'(mat_ready);
      if (busy) clr_cnt += int'(!mean_reset_n);
      if (head_idx > max_idx) max_idx = head_idx;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests++;
    if ({busy, done, mat_ready, mean_enable, mean_compare, mean_reset_n} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {busy, done, mat_ready, mean_enable, mean_compare, mean_reset_n});
    end
    tests++;
    if ({head_idx, prune_mask, keep_count} !== 15'd0) begin
      fails++;
      $display("FAIL reset_data: got idx=%0d mask=%h keep=%0d expected 0/00/0",
               head_idx, prune_mask, keep_count);
    end
    reset = 1'b0;
    step();
    tests++;
    if (mean_reset_n !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_mrn: got %b expected 1", mean_reset_n);
    end
  endtask

  task automatic test_basic();
    int cyc;
    start_pass(4'd4, 8'b0000_1010);
    wait_done(100, cyc);
    tests++;
    if (cyc !== 25) begin
      fails++;
      $display("FAIL basic_done_cycle: got %0d expected 25", cyc);
    end
    tests++;
    if (prune_mask !== 8'b0000_1010) begin
      fails++;
      $display("FAIL basic_mask: got %b expected 00001010", prune_mask);
    end
    tests++;
    if (keep_count !== 4'd2) begin
      fails++;
      $display("FAIL basic_keep: got %0d expected 2", keep_count);
    end
    tests++;
    if (en_cnt !== 12 || cmp_cnt !== 4 || rdy_cnt !== 4 || clr_cnt !== 4) begin
      fails++;
      $display("FAIL basic_ctrl_counts: got en=%0d cmp=%0d rdy=%0d clr=%0d expected 12/4/4/4",
               en_cnt, cmp_cnt, rdy_cnt, clr_cnt);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle_after_done: got busy=%b expected 0", busy);
    end
    step();
    tests++;
    if (done !== 1'b0 || prune_mask !== 8'b0000_1010) begin
      fails++;
      $display("FAIL basic_hold: got done=%b mask=%b expected 0/00001010", done, prune_mask);
    end
  endtask

  task automatic test_all_heads();
    int cyc;
    start_pass(4'd0, 8'hA5);
    wait_done(200, cyc);
    tests++;
    if (cyc !== 49 || max_idx !== 3'd7) begin
      fails++;
      $display("FAIL zero_heads_timing: got cyc=%0d max_idx=%0d expected 49/7", cyc, max_idx);
    end
    tests++;
    if (prune_mask !== 8'hA5 || keep_count !== 4'd4) begin
      fails++;
      $display("FAIL zero_heads_result: got mask=%h keep=%0d expected a5/4", prune_mask, keep_count);
    end
    step();
    start_pass(4'd12, 8'hFF);
    wait_done(200, cyc);
    tests++;
    if (cyc !== 49 || prune_mask !== 8'hFF || keep_count !== 4'd0) begin
      fails++;
      $display("FAIL clamp_heads: got cyc=%0d mask=%h keep=%0d expected 49/ff/0",
               cyc, prune_mask, keep_count);
    end
  endtask

  task automatic test_wait_stall();
    int  cyc;
    int  stall;
    bit  stalled;
    cyc     = -1;
    stall   = 0;
    stalled = 0;
    start_pass(4'd4, 8'h00);
    for (int i = 1; i <= 100; i++) begin
      step();
      if (done) begin
        cyc = i;
        break;
      end
      if (stall > 0) begin
        tests++;
        if (mean_enable !== 1'b0) begin
          fails++;
          $display("FAIL stall_enable: got %b expected 0 at step %0d", mean_enable, i);
        end
        stall--;
        if (stall == 0) mat_valid = 1'b1;
      end
      if (!stalled && busy && head_idx == 3'd2 && !mean_reset_n) begin
        // In CLEAR of head 2: hold mat_valid low for the next five WAIT cycles.
        stalled   = 1;
        stall     = 6;
        mat_valid = 1'b0;
      end
    end
    mat_valid = 1'b1;
    tests++;
    if (cyc !== 30 || keep_count !== 4'd4) begin
      fails++;
      $display("FAIL stall_done: got cyc=%0d keep=%0d expected 30/4", cyc, keep_count);
    end
  endtask

  task automatic test_abort();
    bit found;
    bit done_seen;
    found     = 0;
    done_seen = 0;
    step();
    start_pass(4'd4, 8'b0000_0010);
    for (int i = 0; i < 100; i++) begin
      if (head_idx == 3'd2 && mean_enable && !mean_compare) begin
        found = 1;
        break;
      end
      step();
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL abort_reach_accum: got none expected ACCUM of head 2");
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || mean_reset_n !== 1'b0 || done !== 1'b0 || mean_enable !== 1'b0) begin
      fails++;
      $display("FAIL abort_next: got busy=%b mrn=%b done=%b en=%b expected 0/0/0/0",
               busy, mean_reset_n, done, mean_enable);
    end
    tests++;
    if (prune_mask !== 8'b0000_0010 || keep_count !== 4'd1) begin
      fails++;
      $display("FAIL abort_partial: got mask=%b keep=%0d expected 00000010/1",
               prune_mask, keep_count);
    end
    step();
    tests++;
    if (mean_reset_n !== 1'b1) begin
      fails++;
      $display("FAIL abort_mrn_release: got %b expected 1", mean_reset_n);
    end
    for (int i = 0; i < 40; i++) begin
      done_seen |= done;
      step();
    end
    tests++;
    if (done_seen || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_done: got done_seen=%b busy=%b expected 0/0", done_seen, busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_pass(4'd2, 8'h03);
    step();
    step();
    num_heads = 4'd4;
    start     = 1'b1;
    step();
    start     = 1'b0;
    wait_done(100, cyc);
    tests++;
    if (cyc !== 10 || prune_mask !== 8'h03 || keep_count !== 4'd0) begin
      fails++;
      $display("FAIL busy_start_ignored: got cyc=%0d mask=%h keep=%0d expected 10/03/0",
               cyc, prune_mask, keep_count);
    end
    start_pass(4'd2, 8'h00);
    tests++;
    if (prune_mask !== 8'h00 || keep_count !== 4'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_clear: got mask=%h keep=%0d busy=%b expected 00/0/1",
               prune_mask, keep_count, busy);
    end
    wait_done(100, cyc);
    tests++;
    if (cyc !== 13 || keep_count !== 4'd2) begin
      fails++;
      $display("FAIL restart_done: got cyc=%0d keep=%0d expected 13/2", cyc, keep_count);
    end
    step();
    abort     = 1'b1;
    start     = 1'b1;
    step();
    abort     = 1'b0;
    start     = 1'b0;
    tests++;
    if (busy !== 1'b0 || mean_reset_n !== 1'b1) begin
      fails++;
      $display("FAIL abort_start_idle: got busy=%b mrn=%b expected 0/1", busy, mean_reset_n);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    start_pass(4'd4, 8'h0F);
    for (int i = 0; i < 100; i++) begin
      step();
      if (mean_compare && head_idx == 3'd1) begin
        found = 1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL rst_reach_compare: got none expected COMPARE of head 1");
    end
    reset = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++;
    if ({busy, done, mat_ready, mean_enable, mean_compare, mean_reset_n} !== 6'b0 ||
        {head_idx, prune_mask, keep_count} !== 15'd0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got ctrl=%b idx=%0d mask=%h keep=%0d expected 000000/0/00/0",
               {busy, done, mat_ready, mean_enable, mean_compare, mean_reset_n},
               head_idx, prune_mask, keep_count);
    end
    reset = 1'b0;
    step();
    tests++;
    if (mean_reset_n !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_release: got mrn=%b busy=%b expected 1/0", mean_reset_n, busy);
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    mat_valid = 1'b1;
    num_heads = 4'd0;
    pat       = 8'h00;
    test_reset();
    test_basic();
    test_all_heads();
    test_wait_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/head_prune_ctrl.md
HEAD_PRUNE_CTRL -- requirements
Module: head_prune_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_HEADS, default 8: maximum heads per pass.
- ACC_CYCLES, default 2: mean_enable-only cycles per head before compare.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  begin a pruning pass; sampled only in IDLE.
REQ-005 abort  in  1  synchronous pass cancel.
REQ-006 num_heads  in  4  heads this pass; latched at start.
REQ-007 mat_valid  in  1  both result matrices of current head are stable at the mean unit.
REQ-008 mat_ready  out  1  one-cycle pulse: current head consumed.
REQ-009 mean_enable  out  1  drives the mean unit's enable.
REQ-010 mean_compare  out  1  drives the mean unit's compare flag.
REQ-011 mean_reset_n  out  1  drives the mean unit's active-low _reset.
REQ-012 mean_prune  in  1  PruneHead result from the mean unit.
REQ-013 head_idx  out  3  index of the head in progress.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at pass completion.
REQ-016 prune_mask  out  NUM_HEADS  bit h=1 means head h is pruned.
REQ-017 keep_count  out  4  number of unpruned heads this pass.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, WAIT, ACCUM, COMPARE, SAMPLE and FIN.
REQ-019 IDLE with start=1 SHALL:
- go to CLEAR;
- clear head_idx, prune_mask and keep_count;
- latch num_heads, with 0 or >NUM_HEADS clamped to NUM_HEADS.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 CLEAR SHALL:
- drive mean_reset_n=0 for exactly one cycle;
- then go to WAIT.
REQ-022 WAIT SHALL:
- hold with all mean controls inactive until mat_valid=1;
- then go to ACCUM.
REQ-023 ACCUM SHALL:
- assert mean_enable for exactly ACC_CYCLES cycles, counted by an internal counter;
- then go to COMPARE.
REQ-024 COMPARE SHALL:
- assert mean_enable=1 and mean_compare=1 for one cycle;
- then go to SAMPLE.
REQ-025 SAMPLE SHALL:
- write mean_prune into prune_mask[head_idx];
- increment keep_count if mean_prune=0;
- pulse mat_ready=1 for one cycle.
REQ-026 From SAMPLE, the FSM SHALL go to FIN if head_idx equals latched num_heads-1; otherwise it SHALL increment head_idx and go to CLEAR.
REQ-027 FIN SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-028 prune_mask and keep_count SHALL hold their values in IDLE until the next accepted start.
REQ-029 With mat_valid held high, per-head latency SHALL be 4+ACC_CYCLES cycles. done SHALL rise N*(4+ACC_CYCLES)+1 cycles after the start edge, where N is the latched head count.
REQ-030 mat_valid deasserting in ACCUM, COMPARE or SAMPLE SHALL be ignored. The producer holds data until mat_ready.
REQ-031 abort=1 in any non-IDLE state SHALL:
- go to IDLE next cycle;
- drive mean_reset_n=0 for that one cycle;
- leave prune_mask and keep_count with their partial values;
- never produce done.
REQ-032 abort and start both high in IDLE SHALL leave the block in IDLE.
REQ-033 mean_enable and mean_compare SHALL be registered outputs, glitch-free, and 0 outside ACCUM and COMPARE.

Reset
REQ-034 reset=1 SHALL force all of the following on the next edge:
- state IDLE;
- head_idx=0, prune_mask=0, keep_count=0;
- busy=0, done=0, mat_ready=0;
- mean_enable=0, mean_compare=0, mean_reset_n=0.
REQ-035 The first cycle after reset deasserts SHALL have mean_reset_n=1.
REQ-036 reset SHALL override abort, start and every other input, including mid-pass.

Structure
REQ-037 Package head_prune_pkg SHALL hold the FSM state enum, the NUM_HEADS and ACC_CYCLES defaults, and the data WIDTH=8 shared with the systolic array.
REQ-038 The block SHALL be a single module with no sub-modules. The ACCUM counter and head counter SHALL be inline.

Verification
REQ-039 num_heads=4, mat_valid=1, mean_prune=1 on heads 1 and 3 -> prune_mask=8'b00001010, keep_count=2, done 25 cycles after start.
REQ-040 num_heads=0 -> 8 heads processed, done at cycle 49, head_idx reaches 7.
REQ-041 mat_valid low for 5 cycles in WAIT of head 2 -> mean_enable stays 0 throughout, and done is delayed by exactly 5 cycles.
REQ-042 abort in ACCUM of head 2 -> IDLE next cycle, mean_reset_n=0 for one cycle, no done, prune_mask bits 0-1 retained.
REQ-043 start pulsed while busy -> ignored. A fresh start after done clears prune_mask to 0.
REQ-044 reset asserted mid-COMPARE -> all outputs at reset values next cycle, and mean_reset_n returns to 1 one cycle after reset falls.
